deser_frame_align: RTL
======================

# deser_frame_align

Word-alignment controller placed directly downstream of the ADC deserializer clocking stage. It runs in the divided global clock domain and watches the deserialized ADC frame-clock word. It issues single-cycle BITSLIP pulses to every ISERDES2 in the bank until the frame word equals the expected pattern. It then registers the aligned ADC data words out with a valid flag, and monitors lock continuously.

## Interface
Parameters:
- DESERF, 8: deserialization factor (bits per word per lane).
- NCH, 2: number of ADC data lanes.
- FRAME_PATTERN, 8'hF0: expected frame word when aligned.
- SLIP_WAIT, 4: settle cycles after reset, restart or a slip, before comparing.
- MATCH_COUNT, 16: consecutive matches needed to declare lock.
- MISS_LIMIT, 4: consecutive mismatches while locked that drop lock.

Ports:
- GCLK, input, 1: divided global clock (the x1 deserializer clock); the only clock.
- RESETN, input, 1: asynchronous, active-low reset.
- RESTART, input, 1: synchronous request to re-run alignment; honoured on any cycle it is high.
- FRAME_DATA, input, DESERF: deserialized frame-clock word.
- DATA_IN, input, NCH*DESERF: deserialized ADC words; lane n is bits [n*DESERF +: DESERF].
- BITSLIP, output, 1: one-cycle slip pulse, fanned out to all ISERDES2 of the bank.
- LOCKED, output, 1: alignment achieved.
- ALIGN_ERR, output, 1: all DESERF phases tried without a match.
- SLIP_CNT, output, 4: number of slips issued since the last reset, restart or lock loss.
- DATA_OUT, output, NCH*DESERF: registered DATA_IN.
- DATA_VALID, output, 1: DATA_OUT is aligned; equals LOCKED.

## Operation
- Input stage: FRAME_DATA is registered into frame_q every cycle. All comparisons use frame_q.
- Reset values (async, RESETN low):
  - state = WAIT; all internal counters = 0.
  - All outputs = 0: BITSLIP, LOCKED, ALIGN_ERR, SLIP_CNT, DATA_OUT, DATA_VALID.
- FSM states: WAIT, CHECK, SLIP, LOCKED, ERROR.
- WAIT:
  - Wait counter increments each cycle.
  - At count SLIP_WAIT-1, clear the wait counter and match counter, then go to CHECK.
  - WAIT therefore lasts exactly SLIP_WAIT cycles.
- CHECK:
  - Match (frame_q == FRAME_PATTERN): increment the match counter. If it was MATCH_COUNT-1, go to LOCKED.
  - Mismatch with SLIP_CNT < DESERF-1: go to SLIP.
  - Mismatch with SLIP_CNT == DESERF-1: go to ERROR.
  - A mismatch after partial matches still slips; there is no tolerance while searching.
- SLIP:
  - Lasts exactly one cycle; BITSLIP = 1 only in this state.
  - SLIP_CNT increments; next state is WAIT.
- LOCKED:
  - LOCKED = 1 and DATA_VALID = 1.
  - Miss counter counts consecutive mismatches; any match clears it.
  - On the MISS_LIMIT-th consecutive mismatch, go to WAIT with SLIP_CNT, match and miss counters cleared.
- ERROR:
  - ALIGN_ERR = 1; the block stays here until RESTART or reset.
  - SLIP_CNT holds at DESERF-1.
- RESTART:
  - Highest synchronous priority, from any state.
  - Next state is WAIT; all counters are cleared.
  - LOCKED, DATA_VALID, ALIGN_ERR and BITSLIP are 0 on the following cycle.
- DATA_OUT is registered from DATA_IN every cycle, regardless of state. Consumers qualify it with DATA_VALID.
- Outputs are registered and derived from the state: BITSLIP = (state == SLIP), LOCKED = DATA_VALID = (state == LOCKED), ALIGN_ERR = (state == ERROR).
- SLIP_CNT saturates by construction (never exceeds DESERF-1) and never wraps.

## Timing
- Cycle 0 is the first GCLK edge after RESETN deasserts.
- Each failed attempt costs SLIP_WAIT+2 cycles (WAIT, one CHECK, one SLIP).
- Time to lock with k slips: k*(SLIP_WAIT+2) + SLIP_WAIT + MATCH_COUNT cycles.
  - Defaults: 6k + 20.
- Time to ALIGN_ERR: ALIGN_ERR rises at cycle (DESERF-1)*(SLIP_WAIT+2) + SLIP_WAIT + 1.
  - Defaults: cycle 47.
- BITSLIP is never high on two consecutive cycles. Minimum spacing between pulses is SLIP_WAIT+2 cycles.
- DATA_IN to DATA_OUT latency is 1 cycle.
- Lock loss: LOCKED falls on the cycle after the MISS_LIMIT-th consecutive mismatch is seen in frame_q.
- RESETN asserted mid-slip: BITSLIP drops immediately (asynchronously).

## Test plan
- Bench model: each BITSLIP rotates the frame word left by 1, and FRAME_DATA is held otherwise.
- FRAME_DATA = 8'hF0 constant from reset -> no BITSLIP; LOCKED and DATA_VALID rise at cycle 20; SLIP_CNT = 0.
- Initial frame word 8'h1E -> 3 BITSLIP pulses at cycles 5, 11, 17; LOCKED at cycle 38; SLIP_CNT = 3.
- FRAME_DATA = 8'hAA (never rotates to 8'hF0) -> 7 pulses at cycles 5, 11, ..., 41; ALIGN_ERR at cycle 47; SLIP_CNT = 7; LOCKED stays 0.
- While locked:
  - Inject 3 mismatching words -> LOCKED stays 1.
  - Inject 4 consecutive mismatching words -> LOCKED falls on the next cycle; SLIP_CNT = 0; re-lock occurs after 20 cycles once the pattern returns.
- RESTART pulse while in ERROR, and separately while LOCKED -> ALIGN_ERR/LOCKED = 0 next cycle; full re-alignment sequence repeats with the cycle counts above.
- DATA_IN with lane 0 = 8'h5A and lane 1 = 8'hC3 -> DATA_OUT shows 16'hC35A one cycle later. Assert RESETN low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/deser_frame_align.sv
// deser_frame_align: bitslip-based word aligner for a deserialized ADC bank.
// It watches the frame-clock word and pulses BITSLIP until that word equals
// FRAME_PATTERN, then flags the registered ADC data as valid while lock holds.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WAIT   | settle for SLIP_WAIT cycles after reset/restart/slip/loss
// ST_CHECK  | count consecutive pattern matches; slip or error on a miss
// ST_SLIP   | single-cycle BITSLIP pulse to the whole ISERDES bank
// ST_LOCKED | aligned; data valid; tolerate up to MISS_LIMIT-1 misses
// ST_ERROR  | every phase tried without lock; park until RESTART/reset
module deser_frame_align #(
  parameter int                DESERF        = 8,
  parameter int                NCH           = 2,
  parameter logic [DESERF-1:0] FRAME_PATTERN = 8'hF0,
  parameter int                SLIP_WAIT     = 4,
  parameter int                MATCH_COUNT   = 16,
  parameter int                MISS_LIMIT    = 4
) (
  input  logic                  GCLK,
  input  logic                  RESETN,
  input  logic                  RESTART,
  input  logic [DESERF-1:0]     FRAME_DATA,
  input  logic [NCH*DESERF-1:0] DATA_IN,
  output logic                  BITSLIP,
  output logic                  LOCKED,
  output logic                  ALIGN_ERR,
  output logic [3:0]            SLIP_CNT,
  output logic [NCH*DESERF-1:0] DATA_OUT,
  output logic                  DATA_VALID
);

  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int MISS_W  = $clog2(MISS_LIMIT + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_LIMIT - 1);
  localparam logic [3:0]         SLIP_LAST  = 4'(DESERF - 1);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [MATCH_W-1:0]      match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]       miss_cnt_q, miss_cnt_d;
  logic [3:0]              slip_cnt_q, slip_cnt_d;
  logic [DESERF-1:0]       frame_q, frame_d;
  logic [NCH*DESERF-1:0]   data_out_q, data_out_d;
  logic                    frame_match;

  assign frame_match = (frame_q == FRAME_PATTERN);

  // Input/output pipeline: frame word and ADC data are captured every cycle.
  always_comb begin
    frame_d    = FRAME_DATA;
    data_out_d = DATA_IN;
  end

  // Next-state and counter logic; RESTART overrides everything.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    slip_cnt_d  = slip_cnt_q;

    if (RESTART) begin
      state_d     = ST_WAIT;
      wait_cnt_d  = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      slip_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d  = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            state_d     = ST_CHECK;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (frame_match) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
            end
          end else if (slip_cnt_q < SLIP_LAST) begin
            state_d = ST_SLIP;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_SLIP: begin
          // Only reachable with slip_cnt_q < SLIP_LAST, so this never wraps.
          slip_cnt_d = slip_cnt_q + 1'b1;
          state_d    = ST_WAIT;
        end
        ST_LOCKED: begin
          if (frame_match) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == MISS_LAST) begin
            state_d     = ST_WAIT;
            wait_cnt_d  = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            slip_cnt_d  = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_WAIT;
        end
      endcase
    end
  end

  // State, counters and data registers with asynchronous active-low reset.
  always_ff @(posedge GCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= ST_WAIT;
      wait_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      frame_q     <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      frame_q     <= frame_d;
      data_out_q  <= data_out_d;
    end
  end

  // Status outputs decode the registered state directly, so they are glitch-free
  // and drop the instant reset asserts.
  assign BITSLIP    = (state_q == ST_SLIP);
  assign LOCKED     = (state_q == ST_LOCKED);
  assign DATA_VALID = (state_q == ST_LOCKED);
  assign ALIGN_ERR  = (state_q == ST_ERROR);
  assign SLIP_CNT   = slip_cnt_q;
  assign DATA_OUT   = data_out_q;

endmodule
